// File: rtl/alu_ctrl_pkg.sv
// Shared ALU control codes and the execute-unit state encoding.
// The ALU control decoder imports the same codes.
package alu_ctrl_pkg;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SLL  = 4'b0011;
  localparam logic [3:0] ALU_SLT  = 4'b0100;
  localparam logic [3:0] ALU_SLTU = 4'b0101;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_XOR  = 4'b0111;
  localparam logic [3:0] ALU_SRL  = 4'b1000;
  localparam logic [3:0] ALU_JAL  = 4'b1001;
  localparam logic [3:0] ALU_SRA  = 4'b1010;
  localparam logic [3:0] ALU_REM  = 4'b1011;
  localparam logic [3:0] ALU_DIV  = 4'b1101;
  localparam logic [3:0] ALU_MUL  = 4'b1110;
  localparam logic [3:0] ALU_BNE  = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_FIX  = 2'd3
  } state_t;

  function automatic logic is_divrem(input logic [3:0] code);
    return (code == ALU_DIV) || (code == ALU_REM);
  endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative unsigned engine: shift-add multiply or restoring divide on
// operand magnitudes, one step per cycle over XLEN steps.
module alu_muldiv_iter #(
  parameter int XLEN = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              kill,
  input  logic              is_div,
  input  logic [XLEN-1:0]   mag_a,
  input  logic [XLEN-1:0]   mag_b,
  output logic [2*XLEN-1:0] acc,
  output logic              done
);

  localparam int CW = $clog2(XLEN);

  logic [XLEN-1:0]   b_q;
  logic              div_q;
  logic              busy;
  logic [CW-1:0]     cnt;
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next;
  logic [XLEN:0]     div_trial;
  logic [2*XLEN-1:0] div_next;

  assign done = busy && (cnt == CW'(XLEN - 1));

  // Multiply: acc = {partial product, remaining multiplier bits}.
  // Divide:   acc = {partial remainder, dividend/quotient bits}.
  always_comb begin
    mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, b_q} : '0);
    mul_next  = {mul_sum, acc[XLEN-1:1]};
    div_trial = acc[2*XLEN-1:XLEN-1] - {1'b0, b_q};
    if (div_trial[XLEN]) begin
      div_next = {acc[2*XLEN-2:0], 1'b0};
    end else begin
      div_next = {div_trial[XLEN-1:0], acc[XLEN-2:0], 1'b1};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc   <= '0;
      b_q   <= '0;
      div_q <= 1'b0;
      busy  <= 1'b0;
      cnt   <= '0;
    end else if (kill) begin
      busy <= 1'b0;
      cnt  <= '0;
    end else if (start) begin
      acc   <= is_div ? {{XLEN{1'b0}}, mag_a} : {{XLEN{1'b0}}, mag_b};
      b_q   <= is_div ? mag_b : mag_a;
      div_q <= is_div;
      busy  <= 1'b1;
      cnt   <= '0;
    end else if (busy) begin
      cnt <= cnt + 1'b1;
      acc <= div_q ? div_next : mul_next;
      if (done) begin
        busy <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_exec_unit.sv
// ALU execute stage: single-cycle logical/shift/compare/add ops plus
// iterative signed mul/div/rem, with a valid/ready request side.
module alu_exec_unit
  import alu_ctrl_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      ctrl,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            kill,
  output logic            out_valid,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output state_t          state
);

  // Handshake: a request transfers on a rising edge where in_valid and
  // in_ready are both high and kill is low; in_ready depends only on state.
  // out_valid is a single-cycle pulse with no backpressure.

  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  logic              accept;
  logic              divrem;
  logic              div_zero;
  logic              div_ovf;
  logic              corner;
  logic              long_op;
  logic [4:0]        shamt;
  logic [XLEN-1:0]   sc_result;
  logic              sc_zero;
  logic [XLEN-1:0]   mag_a;
  logic [XLEN-1:0]   mag_b;
  logic              res_neg;
  logic              start;
  logic [2*XLEN-1:0] acc;
  logic              done;
  logic              neg_q;
  logic              rem_q;
  logic [XLEN-1:0]   raw_mag;
  logic [XLEN-1:0]   fix_value;

  assign in_ready = (state == ST_IDLE);
  assign accept   = in_valid && in_ready && !kill;

  assign divrem   = is_divrem(ctrl);
  assign div_zero = (op_b == '0);
  assign div_ovf  = (op_a == INT_MIN) && (op_b == '1);
  assign corner   = divrem && (div_zero || div_ovf);
  assign long_op  = (ctrl == ALU_MUL) || (divrem && !corner);
  assign start    = accept && long_op;
  assign shamt    = op_b[4:0];

  always_comb begin
    sc_result = '0;
    sc_zero   = 1'b0;
    case (ctrl)
      ALU_AND:  sc_result = op_a & op_b;
      ALU_OR:   sc_result = op_a | op_b;
      ALU_XOR:  sc_result = op_a ^ op_b;
      ALU_ADD:  sc_result = op_a + op_b;
      ALU_SLL:  sc_result = op_a << shamt;
      ALU_SRL:  sc_result = op_a >> shamt;
      ALU_SRA:  sc_result = $unsigned($signed(op_a) >>> shamt);
      ALU_SLT:  sc_result = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      ALU_SLTU: sc_result = {{(XLEN-1){1'b0}}, (op_a < op_b)};
      ALU_JAL:  sc_result = op_a + XLEN'(4);
      ALU_SUB: begin
        sc_result = op_a - op_b;
        sc_zero   = (op_a == op_b);
      end
      ALU_BNE: begin
        sc_result = op_a - op_b;
        sc_zero   = (op_a != op_b);
      end
      // Only the corner cases reach here on the single-cycle path.
      ALU_DIV:  sc_result = div_zero ? '1 : INT_MIN;
      ALU_REM:  sc_result = div_zero ? op_a : '0;
      default:  sc_result = '0;
    endcase
  end

  // The engine works on magnitudes; the sign is restored in FIX.
  always_comb begin
    mag_a   = op_a[XLEN-1] ? -op_a : op_a;
    mag_b   = op_b[XLEN-1] ? -op_b : op_b;
    res_neg = (ctrl == ALU_REM) ? op_a[XLEN-1] : (op_a[XLEN-1] ^ op_b[XLEN-1]);
  end

  alu_muldiv_iter #(
    .XLEN (XLEN)
  ) u_muldiv (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .kill    (kill),
    .is_div  (ctrl != ALU_MUL),
    .mag_a   (mag_a),
    .mag_b   (mag_b),
    .acc     (acc),
    .done    (done)
  );

  assign raw_mag   = rem_q ? acc[2*XLEN-1:XLEN] : acc[XLEN-1:0];
  assign fix_value = neg_q ? -raw_mag : raw_mag;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      out_valid <= 1'b0;
      result    <= '0;
      zero      <= 1'b0;
      neg_q     <= 1'b0;
      rem_q     <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (kill) begin
        state <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: begin
            if (accept) begin
              if (long_op) begin
                state <= (ctrl == ALU_MUL) ? ST_MUL : ST_DIV;
                neg_q <= res_neg;
                rem_q <= (ctrl == ALU_REM);
              end else begin
                result    <= sc_result;
                zero      <= sc_zero;
                out_valid <= 1'b1;
              end
            end
          end
          ST_MUL, ST_DIV: begin
            if (done) begin
              state <= ST_FIX;
            end
          end
          ST_FIX: begin
            result    <= fix_value;
            zero      <= 1'b0;
            out_valid <= 1'b1;
            state     <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
